// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU beside the EX-stage ALU.
// Holds the pipeline with div_stall while it divides and pulses div_done when the HI/LO results are final.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ex_div_start,
  input  logic             ex_div_signed,
  input  logic [WIDTH-1:0] ex_A,
  input  logic [WIDTH-1:0] ex_B,
  input  logic             exc_oc,
  output logic             div_stall,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] raw_a;
  logic             sign_q;
  logic             sign_r;
  logic             div0;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // Operand magnitudes; the most negative value maps onto itself, which the
  // unsigned datapath then treats as 2**(WIDTH-1).
  always_comb begin
    a_neg = ex_div_signed & ex_A[WIDTH-1];
    b_neg = ex_div_signed & ex_B[WIDTH-1];
    a_mag = a_neg ? (~ex_A + 1'b1) : ex_A;
    b_mag = b_neg ? (~ex_B + 1'b1) : ex_B;
  end

  // One shift-subtract step. The working remainder is WIDTH+1 bits wide; a
  // restored remainder is always below the divisor, so WIDTH bits are stored.
  always_comb begin
    rem_shift = {prem, dvd[WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, dvs});
    rem_step  = q_bit ? WIDTH'(rem_shift - {1'b0, dvs}) : rem_shift[WIDTH-1:0];
    q_step    = {dvd[WIDTH-2:0], q_bit};
  end

  always_comb begin
    q_final = sign_q ? (~q_step + 1'b1) : q_step;
    r_final = sign_r ? (~rem_step + 1'b1) : rem_step;
    if (div0) begin
      q_final = '1;
      r_final = raw_a;
    end
  end

  always_comb begin
    div_stall = 1'b0;
    div_done  = 1'b0;
    case (state)
      S_IDLE:  div_stall = ex_div_start & ~exc_oc;
      S_BUSY:  div_stall = ~exc_oc;
      S_DONE:  div_done  = 1'b1;
      default: div_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      counter   <= '0;
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      raw_a     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      div0      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_div_start && !exc_oc) begin
            dvd     <= a_mag;
            dvs     <= b_mag;
            raw_a   <= ex_A;
            sign_q  <= a_neg ^ b_neg;
            sign_r  <= a_neg;
            div0    <= (ex_B == '0);
            prem    <= '0;
            counter <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A flush abandons the operation; the result registers keep the last completed result.
          if (exc_oc) begin
            state <= S_IDLE;
          end else begin
            dvd     <= q_step;
            prem    <= rem_step;
            counter <= counter + CNT_W'(1);
            if (counter == LAST_STEP) begin
              quotient  <= q_final;
              remainder <= r_final;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Start is ignored here so the DIV still sitting in EX cannot restart.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands
// compared against an arithmetic reference model.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         ex_div_start = 1'b0;
  logic         ex_div_signed = 1'b0;
  logic [W-1:0] ex_A = '0;
  logic [W-1:0] ex_B = '0;
  logic         exc_oc = 1'b0;
  logic         div_stall;
  logic         div_done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ex_div_start (ex_div_start),
    .ex_div_signed(ex_div_signed),
    .ex_A         (ex_A),
    .ex_B         (ex_B),
    .exc_oc       (exc_oc),
    .div_stall    (div_stall),
    .div_done     (div_done),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  always #5 clk = ~clk;

  // Reference: MIPS semantics via 64-bit arithmetic (truncating division,
  // remainder takes the dividend's sign, overflow wraps to WIDTH bits).
  function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Starts one operation in cycle 0 and watches it; returns the observed cycle
  // of div_done, stall-profile deviations, div_done one cycle later and results.
  task automatic drive_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int done_cyc, output int stall_errs, output logic done_next,
                          output logic [W-1:0] q, output logic [W-1:0] r);
    done_cyc   = -1;
    stall_errs = 0;
    done_next  = 1'b1;
    q          = '0;
    r          = '0;
    @(posedge clk); #1;
    ex_div_start  = 1'b1;
    ex_div_signed = sgn;
    ex_A          = a;
    ex_B          = b;
    for (int c = 0; c < W + 8; c++) begin
      @(negedge clk);
      if (done_cyc >= 0) begin
        done_next = div_done;
        break;
      end
      if (div_stall !== (c <= W)) stall_errs++;
      if (div_done === 1'b1) begin
        done_cyc = c;
        q        = quotient;
        r        = remainder;
      end
      @(posedge clk); #1;
      ex_div_start = 1'b0;
    end
    ex_div_start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got=%b want=0", div_stall); end
    checks++; if (div_done !== 1'b0) begin errors++; $display("FAIL reset_done: got=%b want=0", div_done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient: got=%h want=0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder: got=%h want=0", remainder); end
    #2 resetn = 1'b1;
  endtask

  task automatic test_unsigned();
    int dc, se;
    logic dn;
    logic [W-1:0] q, r;
    drive_op(1'b0, 32'd100, 32'd7, dc, se, dn, q, r);
    checks++; if (dc !== W + 1) begin errors++; $display("FAIL divu_latency: got=%0d want=%0d", dc, W + 1); end
    checks++; if (se !== 0) begin errors++; $display("FAIL divu_stall_profile: bad_cycles=%0d want=0", se); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL divu_done_pulse: done_next=%b want=0", dn); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL divu_quotient: got=%0d want=14", q); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL divu_remainder: got=%0d want=2", r); end
  endtask

  task automatic test_signed();
    int dc, se;
    logic dn;
    logic [W-1:0] q, r;
    drive_op(1'b1, 32'hFFFF_FFF9, 32'd2, dc, se, dn, q, r);
    checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg7_by_2_q: got=%h want=fffffffd", q); end
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg7_by_2_r: got=%h want=ffffffff", r); end
    drive_op(1'b1, 32'd7, 32'hFFFF_FFFE, dc, se, dn, q, r);
    checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_by_neg2_q: got=%h want=fffffffd", q); end
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL div_7_by_neg2_r: got=%h want=00000001", r); end
  endtask

  task automatic test_overflow_div0();
    int dc, se;
    logic dn;
    logic [W-1:0] q, r, a;
    drive_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, dc, se, dn, q, r);
    checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow_q: got=%h want=80000000", q); end
    checks++; if (r !== '0) begin errors++; $display("FAIL div_overflow_r: got=%h want=00000000", r); end
    drive_op(1'b0, 32'h1234_5678, '0, dc, se, dn, q, r);
    checks++; if (dc !== W + 1) begin errors++; $display("FAIL divu_zero_latency: got=%0d want=%0d", dc, W + 1); end
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_q: got=%h want=ffffffff", q); end
    checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL divu_zero_r: got=%h want=12345678", r); end
    a = $urandom() | 32'h8000_0000;
    drive_op(1'b1, a, '0, dc, se, dn, q, r);
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_signed_q: got=%h want=ffffffff", q); end
    checks++; if (r !== a) begin errors++; $display("FAIL div_zero_signed_r: got=%h want=%h", r, a); end
  endtask

  task automatic test_random(input logic sgn, input int n);
    int dc, se;
    logic dn;
    logic [W-1:0] q, r, a, b, eq, er;
    for (int i = 0; i < n; i++) begin
      a = $urandom();
      case ($urandom_range(0, 4))
        0: b = W'($urandom_range(1, 255));
        1: b = $urandom();
        2: b = $urandom() >> $urandom_range(4, 28);
        3: b = '0;
        default: b = 32'hFFFF_FFFF - W'($urandom_range(0, 15));
      endcase
      ref_div(sgn, a, b, eq, er);
      exp_q.push_back(eq);
      exp_q.push_back(er);
      drive_op(sgn, a, b, dc, se, dn, q, r);
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      checks++; if (dc !== W + 1 || se !== 0) begin errors++; $display("FAIL rand_timing: s=%b a=%h b=%h done_cycle=%0d stall_errs=%0d want %0d/0", sgn, a, b, dc, se, W + 1); end
      checks++; if (q !== eq) begin errors++; $display("FAIL rand_quotient: s=%b a=%h b=%h got=%h want=%h", sgn, a, b, q, eq); end
      checks++; if (r !== er) begin errors++; $display("FAIL rand_remainder: s=%b a=%h b=%h got=%h want=%h", sgn, a, b, r, er); end
    end
  endtask

  task automatic test_flush();
    int dc, se, pulses;
    logic dn;
    logic [W-1:0] q, r;
    drive_op(1'b0, 32'd100, 32'd7, dc, se, dn, q, r);
    checks++; if (q !== 32'd14 || r !== 32'd2) begin errors++; $display("FAIL flush_setup: q=%0d r=%0d want 14/2", q, r); end
    @(posedge clk); #1;
    ex_div_start = 1'b1; ex_div_signed = 1'b0; ex_A = 32'd50; ex_B = 32'd5;
    @(negedge clk);
    @(posedge clk); #1;
    ex_div_start = 1'b0;
    repeat (9) @(posedge clk);
    #1 exc_oc = 1'b1;
    @(negedge clk);
    checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL flush_stall_same_cycle: got=%b want=0", div_stall); end
    @(posedge clk); #1;
    exc_oc = 1'b0;
    @(negedge clk);
    checks++; if (div_stall !== 1'b0 || div_done !== 1'b0) begin errors++; $display("FAIL flush_idle_next: stall=%b done=%b want 0/0", div_stall, div_done); end
    pulses = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      if (div_done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_no_done: pulses=%0d want=0", pulses); end
    checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin errors++; $display("FAIL flush_retain: q=%0d r=%0d want 14/2", quotient, remainder); end
  endtask

  task automatic test_back_to_back();
    int k2, pulses;
    @(posedge clk); #1;
    ex_div_start = 1'b1; ex_div_signed = 1'b0; ex_A = 32'd20; ex_B = 32'd4;
    for (int c = 0; c <= W + 1; c++) @(negedge clk);
    checks++; if (div_done !== 1'b1 || div_stall !== 1'b0) begin errors++; $display("FAIL b2b_done_hold: done=%b stall=%b want 1/0", div_done, div_stall); end
    checks++; if (quotient !== 32'd5 || remainder !== 32'd0) begin errors++; $display("FAIL b2b_first: q=%0d r=%0d want 5/0", quotient, remainder); end
    @(posedge clk); #1;
    ex_A = 32'd9; ex_B = 32'd3;
    @(negedge clk);
    checks++; if (div_stall !== 1'b1 || div_done !== 1'b0) begin errors++; $display("FAIL b2b_restart: stall=%b done=%b want 1/0", div_stall, div_done); end
    @(posedge clk); #1;
    ex_div_start = 1'b0;
    k2 = -1;
    for (int k = 1; k <= W + 8; k++) begin
      @(negedge clk);
      if (div_done === 1'b1) begin
        k2 = k;
        break;
      end
      if (k > 1) begin @(posedge clk); end
      if (k == 1) begin @(posedge clk); end
    end
    checks++; if (k2 !== W + 1) begin errors++; $display("FAIL b2b_second_latency: got=%0d want=%0d", k2, W + 1); end
    checks++; if (quotient !== 32'd3 || remainder !== 32'd0) begin errors++; $display("FAIL b2b_second: q=%0d r=%0d want 3/0", quotient, remainder); end
    @(posedge clk); #1;
    ex_div_start = 1'b1; exc_oc = 1'b1; ex_A = 32'd9; ex_B = 32'd3;
    @(negedge clk);
    checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL start_with_flush_stall: got=%b want=0", div_stall); end
    @(posedge clk); #1;
    ex_div_start = 1'b0; exc_oc = 1'b0;
    @(negedge clk);
    checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL start_with_flush_idle: stall=%b want=0", div_stall); end
    pulses = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (div_done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL start_with_flush_done: pulses=%0d want=0", pulses); end
  endtask

  task automatic test_reset_mid();
    int dc, se;
    logic dn;
    logic [W-1:0] q, r;
    @(posedge clk); #1;
    ex_div_start = 1'b1; ex_div_signed = 1'b0; ex_A = 32'h0000_FFFF; ex_B = 32'd17;
    @(negedge clk);
    @(posedge clk); #1;
    ex_div_start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    checks++; if (div_stall !== 1'b1) begin errors++; $display("FAIL reset_mid_busy: stall=%b want=1", div_stall); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (div_stall !== 1'b0 || div_done !== 1'b0) begin errors++; $display("FAIL reset_mid_ctrl: stall=%b done=%b want 0/0", div_stall, div_done); end
    checks++; if (quotient !== '0 || remainder !== '0) begin errors++; $display("FAIL reset_mid_results: q=%h r=%h want 0/0", quotient, remainder); end
    @(posedge clk);
    #3 resetn = 1'b1;
    drive_op(1'b0, 32'd10, 32'd3, dc, se, dn, q, r);
    checks++; if (dc !== W + 1 || se !== 0) begin errors++; $display("FAIL reset_recover_timing: done_cycle=%0d stall_errs=%0d want %0d/0", dc, se, W + 1); end
    checks++; if (q !== 32'd3 || r !== 32'd1) begin errors++; $display("FAIL reset_recover_result: q=%0d r=%0d want 3/1", q, r); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow_div0();
    test_random(1'b0, 10);
    test_random(1'b1, 10);
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for MIPS DIV/DIVU, sitting beside the EX-stage ALU.
- It initiates pipeline-hold requests toward the stall/refresh control unit. While it is dividing, it holds `div_stall` high so the control unit freezes IF/ID and ID/EX and bubbles EX/MEM.
- It accepts the exception flush (`exc_oc`) that the control unit broadcasts, and aborts on it.
- Quotient and remainder are handed to the HI/LO write path when `div_done` pulses.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- ex_div_start  input  1  DIV/DIVU instruction valid in EX stage.
- ex_div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- ex_A  input  WIDTH  dividend (rs), sampled with start.
- ex_B  input  WIDTH  divisor (rt), sampled with start.
- exc_oc  input  1  exception/flush; aborts any operation.
- div_stall  output  1  hold request to control unit.
- div_done  output  1  one-cycle pulse: quotient/remainder valid, write HI/LO.
- quotient  output  WIDTH  LO result, registered.
- remainder  output  WIDTH  HI result, registered.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, counter=0.
  - div_stall=0, div_done=0, quotient=0, remainder=0.
  - Reset mid-operation discards all progress.
- States: IDLE, BUSY, DONE. The state register is the only source of control.
- IDLE:
  - div_stall = ex_div_start && !exc_oc (combinational, same cycle as start).
  - On an edge with start && !exc_oc:
    - latch |A| and |B| (magnitudes when signed, raw when unsigned);
    - latch sign_q = A[W-1]^B[W-1] and sign_r = A[W-1] (both forced 0 for unsigned);
    - latch div0 = (B==0);
    - clear partial remainder; counter=0; go BUSY.
- BUSY:
  - div_stall = !exc_oc.
  - Each edge performs one shift-subtract step: partial remainder is WIDTH+1 bits; a quotient bit is shifted in LSB-first from the dividend MSB side; counter++.
  - On the edge where counter==WIDTH-1:
    - write the final corrected results into quotient/remainder;
    - go DONE.
  - Total: exactly WIDTH BUSY cycles.
- Sign correction (applied at that final edge):
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r (two's complement, WIDTH-bit wrap).
  - 0x80000000 / 0xFFFFFFFF signed gives quotient=0x80000000, remainder=0. No trap.
- Divide by zero:
  - Same latency as a normal divide.
  - quotient=all ones, remainder=ex_A as sampled. No sign correction, no exception.
- DONE:
  - div_done=1 for exactly one cycle; div_stall=0 so the pipeline advances the DIV out of EX.
  - ex_div_start is ignored in DONE, so the same instruction cannot restart.
  - Next edge goes to IDLE.
- Latency: start seen in cycle 0.
  - div_stall high in cycles 0..WIDTH (WIDTH+1 cycles).
  - div_done high in cycle WIDTH+1, with quotient/remainder valid in that same cycle.
- quotient/remainder hold their values until the next successful completion. Aborts never modify them.
- Flush (exc_oc=1):
  - In any state, the next edge goes to IDLE.
  - div_stall is forced 0 in the same cycle.
  - div_done is not asserted; outputs are unchanged.
  - exc_oc in DONE: the div_done pulse still occurs, because the result is already final. HI/LO write suppression is the writer's responsibility.
- Simultaneous start and exc_oc in IDLE: start is ignored.
- Counter width is clog2(WIDTH); it wraps only through the reset to 0 on entry to BUSY.

Test Plan:
- Unsigned divide: DIVU 100/7 -> div_stall high cycles 0..32; div_done=1 at cycle 33; quotient=14, remainder=2; div_done=0 at cycle 34.
- Signed divide: DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
- Overflow and divide by zero:
  - DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - DIVU 0x12345678 / 0 -> quotient=0xFFFFFFFF, remainder=0x12345678; div_done at cycle 33.
- Flush mid-divide: complete 100/7 first, then start 50/5; pulse exc_oc at cycle 10 -> div_stall=0 in cycle 10; IDLE at cycle 11; no div_done; quotient=14, remainder=2 retained.
- Back-to-back and hold:
  - Keep ex_div_start=1 through DONE -> no restart in DONE.
  - Restart occurs in the following IDLE cycle; the second op 9/3 gives quotient=3, remainder=0.
  - Start with exc_oc=1 in IDLE -> no stall, stays IDLE.
- Reset: deassert resetn asynchronously at BUSY cycle 20 -> all outputs 0 immediately. After release, a new DIVU 10/3 gives quotient=3, remainder=1 with normal latency.
